// File: rtl/serial_encoder_link.sv
// Link layer: assembles received bytes into encoder input words, buffers encoder
// output words in a FIFO and serialises them as optionally framed transmit bytes.
module serial_encoder_link #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 24,
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [IN_W-1:0]          enc_in,
    output logic                     enc_in_valid,
    input  logic [OUT_W-1:0]         enc_out,
    input  logic                     enc_out_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [1:0]               mode,
    input  logic                     clear_err,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int unsigned K  = IN_W / 8;
    localparam int unsigned NB = OUT_W / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned NW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_e;

    logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [IN_W-1:0]  asm_q, asm_d;
    logic [IN_W-1:0]  enc_in_q, enc_in_d;
    logic             enc_in_valid_q, enc_in_valid_d;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty, pop, push_ok, drop;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       csum_q, csum_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [OUT_W-1:0] rd_word;
    logic [1:0]       mode_eff;

    assign fifo_full  = (level_q == LW'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign push_ok    = enc_out_valid && (!fifo_full || pop);
    assign drop       = enc_out_valid && !push_ok;
    assign rd_word    = mem_q[rd_ptr_q];
    assign mode_eff   = (mode == 2'b11) ? 2'b00 : mode;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        enc_in_d       = enc_in_q;
        enc_in_valid_d = 1'b0;
        if (rx_valid) begin
            asm_d = (asm_q << 8) | IN_W'(rx_data);
            if (byte_cnt_q == CW'(K - 1)) begin
                byte_cnt_d     = '0;
                enc_in_d       = asm_d;
                enc_in_valid_d = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
        end

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);
        // A drop wins over a simultaneous clear so the lost word is never hidden.
        ovf_d    = drop ? 1'b1 : (clear_err ? 1'b0 : ovf_q);

        state_d    = state_q;
        shreg_d    = shreg_q;
        mode_d     = mode_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (pop) begin
                    shreg_d    = rd_word;
                    mode_d     = mode_eff;
                    csum_d     = '0;
                    cnt_d      = '0;
                    tx_valid_d = 1'b1;
                    if (mode_eff != 2'b00) begin
                        state_d   = S_HDR;
                        tx_data_d = HDR;
                    end else begin
                        state_d   = S_DATA;
                        tx_data_d = rd_word[OUT_W-1 -: 8];
                    end
                end
            end
            S_HDR: begin
                if (tx_ready) begin
                    state_d   = S_DATA;
                    tx_data_d = shreg_q[OUT_W-1 -: 8];
                end
            end
            S_DATA: begin
                if (tx_ready) begin
                    csum_d  = csum_q ^ tx_data_q;
                    shreg_d = shreg_q << 8;
                    if (cnt_q == NW'(NB - 1)) begin
                        if (mode_q == 2'b10) begin
                            state_d   = S_CSUM;
                            tx_data_d = csum_d;
                        end else begin
                            state_d    = S_IDLE;
                            tx_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d     = cnt_q + NW'(1);
                        tx_data_d = shreg_d[OUT_W-1 -: 8];
                    end
                end
            end
            S_CSUM: begin
                if (tx_ready) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage is left unreset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= enc_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            enc_in_q       <= '0;
            enc_in_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            ovf_q          <= 1'b0;
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            mode_q         <= 2'b00;
            csum_q         <= '0;
            cnt_q          <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
        end else begin
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            enc_in_q       <= enc_in_d;
            enc_in_valid_q <= enc_in_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            ovf_q          <= ovf_d;
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            mode_q         <= mode_d;
            csum_q         <= csum_d;
            cnt_q          <= cnt_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
        end
    end

    assign enc_in       = enc_in_q;
    assign enc_in_valid = enc_in_valid_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign ovf          = ovf_q;
    assign fifo_level   = level_q;
endmodule

// File: tb/tb_serial_encoder_link.sv
// Scoreboard bench for serial_encoder_link (IN_W=16, OUT_W=24, DEPTH=8): directed
// stimulus queues expected bytes/words, negedge monitors pop and compare.
module tb_serial_encoder_link;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] enc_in;
    logic        enc_in_valid;
    logic [23:0] enc_out;
    logic        enc_out_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  mode;
    logic        clear_err;
    logic        ovf;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  exp_tx  [$];
    logic [15:0] exp_enc [$];

    serial_encoder_link #(.IN_W(16), .OUT_W(24), .DEPTH(8), .HDR(8'hA5)) dut (
        .clk(clk), .reset(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .enc_in(enc_in), .enc_in_valid(enc_in_valid),
        .enc_out(enc_out), .enc_out_valid(enc_out_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mode(mode), .clear_err(clear_err), .ovf(ovf), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [23:0] w);
        enc_out       = w;
        enc_out_valid = 1'b1;
        tick();
        enc_out_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [23:0] w, input logic [1:0] m);
        logic [7:0] cs;
        cs = w[23:16] ^ w[15:8] ^ w[7:0];
        if (m == 2'b01 || m == 2'b10) exp_tx.push_back(8'hA5);
        exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);
        exp_tx.push_back(w[7:0]);
        if (m == 2'b10) exp_tx.push_back(cs);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_tx.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, exp_tx.size(), 0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Scoreboard monitors: compare every accepted byte and every assembled word.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_tx.pop_front());
            end
        end
        if (rst_n && enc_in_valid) begin
            if (exp_enc.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL enc_unexpected: got %0h expected none", enc_in);
            end else begin
                check("enc_in", enc_in, exp_enc.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; enc_out = '0; enc_out_valid = 1'b0;
        tx_ready = 1'b1; mode = 2'b00; clear_err = 1'b0;
        #3;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_enc_in", enc_in, 0);
        check("rst_enc_in_valid", enc_in_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", fifo_level, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Raw mode: 12,34,56 on consecutive cycles then one idle cycle.
        expect_word(24'h123456, 2'b00);
        push_word(24'h123456);
        check("raw_level_after_push", fifo_level, 1);
        check("raw_idle_before_pop", tx_valid, 0);
        tick();
        check("raw_valid_b0", tx_valid, 1);
        check("raw_level_after_pop", fifo_level, 0);
        tick();
        check("raw_valid_b1", tx_valid, 1);
        tick();
        check("raw_valid_b2", tx_valid, 1);
        tick();
        check("raw_idle_gap", tx_valid, 0);
        check("raw_drained", exp_tx.size(), 0);

        // Header + data + checksum, then header + data.
        mode = 2'b10;
        expect_word(24'h123456, 2'b10);
        push_word(24'h123456);
        tick();
        mode = 2'b00;  // latched at pop, must not affect this word
        wait_drain("csum_drain");
        mode = 2'b01;
        expect_word(24'h123456, 2'b01);
        push_word(24'h123456);
        tick();
        wait_drain("hdr_drain");
        mode = 2'b11;
        expect_word(24'hC0FFEE, 2'b00);
        push_word(24'hC0FFEE);
        tick();
        wait_drain("mode11_drain");
        mode = 2'b00;

        // Backpressure: byte 12 holds while tx_ready is low.
        tx_ready = 1'b0;
        expect_word(24'h123456, 2'b00);
        push_word(24'h123456);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", tx_valid, 1);
            check("bp_hold_data", tx_data, 8'h12);
            tick();
        end
        tx_ready = 1'b1;
        wait_drain("bp_drain");

        // Overflow: 9 words fit (one in the serialiser), the 10th is dropped.
        tx_ready = 1'b0;
        for (int w = 1; w <= 9; w++) begin
            expect_word(24'(w), 2'b00);
            push_word(24'(w));
        end
        check("ovf_level_full", fifo_level, 8);
        check("ovf_not_yet", ovf, 0);
        push_word(24'd10);
        check("ovf_set", ovf, 1);
        check("ovf_level_hold", fifo_level, 8);
        clear_err = 1'b1;
        push_word(24'd11);
        clear_err = 1'b0;
        check("ovf_clear_vs_drop", ovf, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf_cleared", ovf, 0);
        tx_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_level_empty", fifo_level, 0);

        // Assembly: AB,CD -> ABCD one cycle after CD; EF starts a new word.
        exp_enc.push_back(16'hABCD);
        send_rx(8'hAB);
        check("asm_no_strobe_1st", enc_in_valid, 0);
        send_rx(8'hCD);
        check("asm_strobe", enc_in_valid, 1);
        check("asm_word", enc_in, 16'hABCD);
        send_rx(8'hEF);
        check("asm_no_strobe_3rd", enc_in_valid, 0);
        exp_enc.push_back(16'hEF12);
        send_rx(8'h12);
        tick();
        check("asm_single_pulse", enc_in_valid, 0);

        // Reset mid-frame during byte 34, with a partial rx word pending.
        exp_tx.push_back(8'h12);
        rx_data = 8'h77;
        rx_valid = 1'b1;
        push_word(24'h123456);
        rx_valid = 1'b0;
        tick();
        tick();
        check("mid_data_34", tx_data, 8'h34);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_sent_12", exp_tx.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_enc.push_back(16'h8899);
        send_rx(8'h88);
        send_rx(8'h99);
        expect_word(24'hA1B2C3, 2'b00);
        push_word(24'hA1B2C3);
        tick();
        check("post_rst_msb", tx_data, 8'hA1);
        wait_drain("post_rst_drain");
        tick();
        check("enc_queue_empty", exp_enc.size(), 0);
        check("tx_queue_empty", exp_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_encoder_link.md
# serial_encoder_link

Parametrised link layer between the UART receiver, the turbo encoder and the UART transmitter. It assembles received bytes into encoder input words and buffers encoder output words in a FIFO. It then serialises each word into transmit bytes under a valid/ready handshake, with an optional frame header and XOR checksum. It replaces direct wiring of the receiver/encoder/transmitter and adds buffering, backpressure and framing.

## Interface

- IN_W, 8 — encoder input width in bits; multiple of 8, 8..32
- OUT_W, 24 — encoder output width in bits; multiple of 8, 8..96
- DEPTH, 8 — output FIFO depth in words; power of 2, ≥2
- HDR, 8'hA5 — frame header byte
- clk  in  1  — system clock, all logic on rising edge
- reset  in  1  — asynchronous, active-low reset
- rx_data  in  8  — received byte
- rx_valid  in  1  — one-cycle strobe, rx_data valid
- enc_in  out  IN_W  — assembled encoder input word
- enc_in_valid  out  1  — one-cycle strobe, enc_in valid
- enc_out  in  OUT_W  — encoder output word
- enc_out_valid  in  1  — one-cycle strobe, enc_out valid; no ready, push-or-drop
- tx_data  out  8  — byte to transmitter
- tx_valid  out  1  — tx_data valid
- tx_ready  in  1  — transmitter accepts; transfer when tx_valid && tx_ready
- mode  in  2  — 00 raw, 01 header+data, 10 header+data+checksum, 11 treated as 00
- clear_err  in  1  — clears ovf (synchronous)
- ovf  out  1  — sticky, encoder word dropped on full FIFO
- fifo_level  out  $clog2(DEPTH)+1  — words currently stored

## Operation

- Reset (reset=0): enc_in=0, enc_in_valid=0, tx_data=0, tx_valid=0, ovf=0, fifo_level=0; byte counter 0; FSM IDLE. Reset mid-frame discards the partial input word, FIFO contents and the word in flight.
- Assembler: K=IN_W/8 bytes, first byte is the MSB. A byte counter 0..K-1 increments on rx_valid and wraps to 0 on the K-th byte. On the K-th byte the register enc_in is loaded and enc_in_valid pulses once.
- FIFO: a push happens on enc_out_valid. It is accepted if not full, or if full with a pop in the same cycle. Otherwise the word is dropped and ovf is set.
  - Pop only from the serialiser in IDLE.
  - ovf holds until clear_err=1. Simultaneous clear_err and drop leaves ovf=1.
- Serialiser FSM, states IDLE, HDR, DATA, CSUM:
  - IDLE: if FIFO is non-empty, pop into the shift register, latch mode, clear the checksum accumulator. Go to HDR if the latched mode is 01/10, else DATA.
  - HDR: present HDR; on transfer go to DATA.
  - DATA: present OUT_W/8 bytes, MSB first. XOR each byte into the accumulator on transfer. After the last byte go to CSUM if the latched mode is 10, else IDLE.
  - CSUM: present the accumulator; on transfer go to IDLE.
- tx_valid is high in HDR, DATA and CSUM. tx_data and tx_valid are stable while tx_valid && !tx_ready.
- A mode change mid-word has no effect until the next pop.

## Timing

- enc_in_valid is asserted the cycle after the rx_valid of the K-th byte.
- Push latency: a word pushed at cycle t is counted in fifo_level at t+1.
- Pop latency: from IDLE with a non-empty FIFO, pop at cycle t, first tx_valid at t+1. With a continuously high tx_ready, one byte transfers per cycle.
- One IDLE cycle separates consecutive words (no tx_valid that cycle).
- Same-cycle push and pop: fifo_level is unchanged, and the pushed word is stored behind existing entries.
- FIFO read/write pointers wrap modulo DEPTH; full/empty is taken from fifo_level.

## Test plan

- Raw mode, defaults, tx_ready=1: enc_out=24'h123456 strobe -> tx bytes 12,34,56 on consecutive cycles, then one idle cycle; fifo_level returns to 0.
- mode=10: enc_out=24'h123456 -> A5,12,34,56,70 (checksum 12^34^56=70); mode=01 -> A5,12,34,56.
- Backpressure: tx_ready=0 for 5 cycles while tx_valid=1 with tx_data=12 -> tx_data holds at 12; release -> 34 and 56 follow, no byte lost or repeated.
- Overflow: DEPTH=8, tx_ready=0, 9 strobes of words 1..9 -> fifo_level=8 (one word popped into the serialiser, so 8 remain stored), ovf=0. A 10th strobe -> ovf=1, word 10 lost. clear_err -> ovf=0. Release -> words 1..9 emitted in order.
- Assembly with IN_W=16: rx bytes AB, CD -> enc_in=16'hABCD with a single enc_in_valid pulse one cycle after CD. A third byte EF starts a new word without a strobe.
- Reset mid-frame: reset low during the DATA byte 34 -> tx_valid=0, fifo_level=0, ovf=0 asynchronously. After release, a new word transmits correctly starting from its MSB.
